// File: rtl/cell_bist_ctrl_if.sv
// Bundle of the BIST controller's run-control and cell-under-test signals.
// The slave side is the controller; the master side is the test environment
// that owns the cell under test and the expected truth table.
interface cell_bist_ctrl_if;
    logic        start;
    logic        abort;
    logic [15:0] tt;
    logic        cell_z;
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_cnt;
    logic [3:0]  fail_vec;
    logic        fail_seen;

    modport master (
        output start, abort, tt, cell_z,
        input  vec, busy, done, pass, err_cnt, fail_vec, fail_seen
    );

    modport slave (
        input  start, abort, tt, cell_z,
        output vec, busy, done, pass, err_cnt, fail_vec, fail_seen
    );
endinterface

// File: rtl/cell_bist_ctrl.sv
// Exhaustive BIST controller for a small combinational cell.
// Walks every input vector 0..2^NIN-1, waits SETTLE cycles after applying
// each one, compares the cell output against the expected truth table and
// keeps a mismatch count plus the first failing vector.
module cell_bist_ctrl #(
    parameter int NIN    = 4,
    parameter int SETTLE = 1
) (
    input  logic            cp,
    input  logic            rst,
    cell_bist_ctrl_if.slave bus
);

    // Highest vector index of a run; also the mask for the live vec bits.
    localparam logic [3:0] LAST_IDX  = 4'((1 << NIN) - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  idx_r;
    logic [3:0]  idx_s;
    logic [3:0]  settle_r;
    logic [3:0]  settle_s;
    logic [3:0]  vec_r;
    logic [3:0]  vec_s;
    logic        busy_r;
    logic        busy_s;
    logic        done_r;
    logic        done_s;
    logic        pass_r;
    logic        pass_s;
    logic [4:0]  err_cnt_r;
    logic [4:0]  err_cnt_s;
    logic [3:0]  fail_vec_r;
    logic [3:0]  fail_vec_s;
    logic        fail_seen_r;
    logic        fail_seen_s;
    logic        mismatch_s;

    // Clears vector bits that do not exist for this cell width.
    function automatic logic [3:0] mask_vec(input logic [3:0] v);
        return v & LAST_IDX;
    endfunction

    // Run states in which a vector is being driven to the cell.
    function automatic logic is_busy(input state_t s);
        return (s == APPLY) || (s == WAIT) || (s == SAMPLE);
    endfunction

    // Sequencer state register.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode plus next values of the counters and result flags.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        settle_s    = settle_r;
        err_cnt_s   = err_cnt_r;
        fail_vec_s  = fail_vec_r;
        fail_seen_s = fail_seen_r;
        pass_s      = pass_r;
        done_s      = 1'b0;
        mismatch_s  = 1'b0;
        busy_s      = 1'b0;
        vec_s       = 4'd0;

        case (state_r)
            IDLE: begin
                // A start coinciding with abort is not accepted.
                if (bus.start && !bus.abort) begin
                    state_s     = APPLY;
                    idx_s       = 4'd0;
                    err_cnt_s   = 5'd0;
                    fail_vec_s  = 4'd0;
                    fail_seen_s = 1'b0;
                    pass_s      = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    state_s = IDLE;
                    pass_s  = 1'b0;
                end else begin
                    settle_s = SETTLE_LD;
                    if (SETTLE_LD == 4'd0) begin
                        state_s = SAMPLE;
                    end else begin
                        state_s = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.abort) begin
                    state_s = IDLE;
                    pass_s  = 1'b0;
                end else begin
                    settle_s = settle_r - 4'd1;
                    if (settle_r <= 4'd1) begin
                        state_s = SAMPLE;
                    end else begin
                        state_s = WAIT;
                    end
                end
            end
            SAMPLE: begin
                // Abort wins: the comparison of this cycle is dropped.
                if (bus.abort) begin
                    state_s = IDLE;
                    pass_s  = 1'b0;
                end else begin
                    mismatch_s = (bus.cell_z != bus.tt[idx_r]);
                    if (mismatch_s) begin
                        err_cnt_s = err_cnt_r + 5'd1;
                        if (!fail_seen_r) begin
                            fail_seen_s = 1'b1;
                            fail_vec_s  = idx_r;
                        end else begin
                            fail_seen_s = fail_seen_r;
                        end
                    end else begin
                        err_cnt_s = err_cnt_r;
                    end
                    // idx stops at the last vector rather than wrapping.
                    if (idx_r == LAST_IDX) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + 4'd1;
                        state_s = APPLY;
                    end
                end
            end
            DONE: begin
                done_s  = 1'b1;
                pass_s  = (err_cnt_r == 5'd0);
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // vec follows idx for the whole vector slot and is 0 outside a run.
        busy_s = is_busy(state_s);
        if (busy_s) begin
            vec_s = mask_vec(idx_s);
        end else begin
            vec_s = 4'd0;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            idx_r       <= 4'd0;
            settle_r    <= 4'd0;
            vec_r       <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_cnt_r   <= 5'd0;
            fail_vec_r  <= 4'd0;
            fail_seen_r <= 1'b0;
        end else begin
            idx_r       <= idx_s;
            settle_r    <= settle_s;
            vec_r       <= vec_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            err_cnt_r   <= err_cnt_s;
            fail_vec_r  <= fail_vec_s;
            fail_seen_r <= fail_seen_s;
        end
    end

    assign bus.vec       = vec_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.fail_vec  = fail_vec_r;
    assign bus.fail_seen = fail_seen_r;

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Bench for cell_bist_ctrl. Three instances cover the configurations
// NIN=2/SETTLE=1, NIN=2/SETTLE=0 and NIN=4/SETTLE=0. Each instance drives a
// modelled cell whose response is a lookup table indexed by vec. Expected
// behaviour is computed from the run arithmetic: slot length SETTLE+2,
// vector v judged at edge (v+1)*(SETTLE+2) after start, done one edge after
// the DONE state.
module tb_cell_bist_ctrl;

    logic             cp;
    logic             rst;
    logic [2:0]       start_a;
    logic [2:0]       abort_a;
    logic [2:0][15:0] tt_a;
    logic [2:0][15:0] resp_a;
    logic [2:0][3:0]  vec_o;
    logic [2:0][3:0]  fail_vec_o;
    logic [2:0][4:0]  err_o;
    logic [2:0]       busy_o;
    logic [2:0]       done_o;
    logic [2:0]       pass_o;
    logic [2:0]       fail_seen_o;
    int               n_checks;
    int               n_errors;

    function automatic int nin_of(input int k);
        return (k == 2) ? 4 : 2;
    endfunction

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cell_bist_ctrl_if bus ();

        assign bus.start  = start_a[g];
        assign bus.abort  = abort_a[g];
        assign bus.tt     = tt_a[g];
        assign bus.cell_z = resp_a[g][bus.vec];

        assign vec_o[g]       = bus.vec;
        assign busy_o[g]      = bus.busy;
        assign done_o[g]      = bus.done;
        assign pass_o[g]      = bus.pass;
        assign err_o[g]       = bus.err_cnt;
        assign fail_vec_o[g]  = bus.fail_vec;
        assign fail_seen_o[g] = bus.fail_seen;

        cell_bist_ctrl #(
            .NIN    ((g == 2) ? 4 : 2),
            .SETTLE ((g == 0) ? 1 : 0)
        ) u_dut (
            .cp  (cp),
            .rst (rst),
            .bus (bus)
        );
    end

    // Free-running clock.
    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input int k, input string tag);
        check_val({tag, "_vec"}, 32'(vec_o[k]), 32'd0);
        check_val({tag, "_busy"}, 32'(busy_o[k]), 32'd0);
        check_val({tag, "_done"}, 32'(done_o[k]), 32'd0);
        check_val({tag, "_pass"}, 32'(pass_o[k]), 32'd0);
        check_val({tag, "_err"}, 32'(err_o[k]), 32'd0);
        check_val({tag, "_fvec"}, 32'(fail_vec_o[k]), 32'd0);
        check_val({tag, "_fseen"}, 32'(fail_seen_o[k]), 32'd0);
    endtask

    // One run on instance k. abort_edge > 0 raises abort so it is seen at
    // that edge after start; poke_e >= 0 raises a spurious start so it is
    // seen at edge poke_e+1. Called and returns at 1 time unit after an edge.
    task automatic run_one(input int k, input logic [15:0] tt, input logic [15:0] resp,
                           input int abort_edge, input int poke_e);
        int         n;
        int         per;
        int         total;
        int         lim;
        int         ecnt;
        int         fv;
        int         stop;
        logic       fs;
        logic       aborted;
        logic       exp_busy;
        logic       exp_done;
        logic [3:0] exp_vec;

        n     = 1 << nin_of(k);
        per   = settle_of(k) + 2;
        total = n * per;
        lim   = (abort_edge > 0) ? abort_edge - 1 : total;
        ecnt  = 0;
        fv    = 0;
        fs    = 1'b0;
        for (int v = 0; v < n; v++) begin
            if (((v + 1) * per <= lim) && (tt[v] != resp[v])) begin
                if (!fs) begin
                    fs = 1'b1;
                    fv = v;
                end
                ecnt++;
            end
        end
        stop = (abort_edge > 0) ? abort_edge + 2 : total + 2;

        tt_a[k]    = tt;
        resp_a[k]  = resp;
        start_a[k] = 1'b1;
        @(posedge cp);
        #1;
        start_a[k] = 1'b0;

        for (int e = 0; e <= stop; e++) begin
            if (e > 0) begin
                @(posedge cp);
                #1;
            end
            start_a[k] = 1'b0;
            abort_a[k] = 1'b0;
            aborted = (abort_edge > 0) && (e >= abort_edge);
            if (aborted || (e >= total)) begin
                exp_busy = 1'b0;
                exp_vec  = 4'd0;
                exp_done = !aborted && (e == total + 1);
            end else begin
                exp_busy = 1'b1;
                exp_vec  = 4'(e / per);
                exp_done = 1'b0;
            end
            check_val("busy", 32'(busy_o[k]), 32'(exp_busy));
            check_val("vec", 32'(vec_o[k]), 32'(exp_vec));
            check_val("done", 32'(done_o[k]), 32'(exp_done));
            if (e == 0) begin
                check_val("err_cleared", 32'(err_o[k]), 32'd0);
                check_val("fseen_cleared", 32'(fail_seen_o[k]), 32'd0);
                check_val("pass_cleared", 32'(pass_o[k]), 32'd0);
            end
            if ((abort_edge > 0) && (e == abort_edge - 1)) begin
                abort_a[k] = 1'b1;
            end
            if ((e == poke_e) && ((abort_edge <= 0) || (e + 1 < abort_edge))) begin
                start_a[k] = 1'b1;
            end
        end

        check_val("err_cnt", 32'(err_o[k]), 32'(ecnt));
        check_val("fail_seen", 32'(fail_seen_o[k]), 32'(fs));
        check_val("fail_vec", 32'(fail_vec_o[k]), fs ? 32'(fv) : 32'd0);
        check_val("pass", 32'(pass_o[k]), 32'((abort_edge <= 0) && (ecnt == 0)));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start_a  = '0;
        abort_a  = '0;
        tt_a     = '0;
        resp_a   = '0;

        // Reset state of every instance.
        #12;
        for (int k = 0; k < 3; k++) begin
            check_all_zero(k, "reset");
        end
        @(negedge cp);
        rst = 1'b0;
        @(posedge cp);
        #1;

        // AND cell against tt=0x8, SETTLE=1: clean run, done 13 edges after start.
        run_one(0, 16'h0008, 16'h0008, -1, -1);
        // OR cell against tt=0x8, SETTLE=0: mismatches at vectors 1 and 2.
        run_one(1, 16'h0008, 16'h000E, -1, -1);
        // Constant-0 cell against all-ones table, NIN=4: every vector fails.
        run_one(2, 16'hFFFF, 16'h0000, -1, -1);
        // Abort seen at the edge leaving SAMPLE of vector 2 (2*3+3).
        run_one(0, 16'h0000, 16'h000F, 9, -1);
        // Spurious start while busy; this run leaves err_cnt=2.
        run_one(1, 16'h0005, 16'h0003, -1, 3);

        // start together with abort in IDLE is ignored; results hold.
        start_a[1] = 1'b1;
        abort_a[1] = 1'b1;
        @(posedge cp);
        #1;
        start_a[1] = 1'b0;
        abort_a[1] = 1'b0;
        check_val("idle_start_abort_busy", 32'(busy_o[1]), 32'd0);
        check_val("idle_start_abort_err", 32'(err_o[1]), 32'd2);
        @(posedge cp);
        #1;
        check_val("idle_start_abort_busy2", 32'(busy_o[1]), 32'd0);

        // Clean restart with a spurious start while in DONE (edge 9 = DONE exit).
        run_one(1, 16'h0005, 16'h0005, -1, 8);

        // Asynchronous reset in the WAIT slot of vector 1.
        tt_a[0]    = 16'h0000;
        resp_a[0]  = 16'h000F;
        start_a[0] = 1'b1;
        @(posedge cp);
        #1;
        start_a[0] = 1'b0;
        repeat (4) begin
            @(posedge cp);
            #1;
        end
        check_val("pre_rst_busy", 32'(busy_o[0]), 32'd1);
        check_val("pre_rst_vec", 32'(vec_o[0]), 32'd1);
        check_val("pre_rst_err", 32'(err_o[0]), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero(0, "async_rst");
        #2;
        rst = 1'b0;
        @(posedge cp);
        #1;
        check_all_zero(0, "post_rst");
        run_one(0, 16'h0006, 16'h0004, -1, -1);

        // Randomised runs across all configurations.
        for (int it = 0; it < 24; it++) begin
            int          k;
            int          total;
            int          ab;
            int          pk;
            logic [15:0] tt;
            logic [15:0] resp;
            k     = int'($urandom_range(2, 0));
            total = (1 << nin_of(k)) * (settle_of(k) + 2);
            tt    = 16'($urandom);
            if ($urandom_range(3, 0) == 0) begin
                resp = tt;
            end else begin
                resp = tt ^ 16'($urandom & $urandom);
            end
            if ($urandom_range(3, 0) == 0) begin
                ab = int'($urandom_range(total, 1));
            end else begin
                ab = -1;
            end
            if ($urandom_range(1, 0) == 0) begin
                pk = int'($urandom_range(total, 0));
            end else begin
                pk = -1;
            end
            run_one(k, tt, resp, ab, pk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
